// File: rtl/disp_switch_pkg.sv
// Shared constants for the classify-and-route stage: arbitration modes and
// default word geometry.
package disp_switch_pkg;

    localparam int DEF_DATA_SIZE = 10;
    localparam int DEF_MAIN_SIZE = 8;

    typedef enum logic {
        PRIO_STRICT = 1'b0,
        PRIO_RR     = 1'b1
    } prio_e;

    function automatic logic is_round_robin(input int mode);
        return mode == int'(PRIO_RR);
    endfunction

endpackage

// File: rtl/disp_switch_sync_fifo.sv
// Single-clock FIFO with occupancy flags; a push into a full FIFO is accepted
// only when a pop happens in the same cycle, otherwise it is dropped.
module sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic             o_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty        = (r_count == '0);
    assign o_full         = (r_count == CNT_W'(DEPTH));
    assign o_almost_full  = (r_count >= CNT_W'(AF_THRESH));
    assign o_almost_empty = (r_count <= CNT_W'(AE_THRESH));

    assign w_rd_en = i_pop & ~o_empty;
    assign w_wr_en = i_push & (~o_full | w_rd_en);
    assign o_drop  = i_push & ~w_wr_en;

    // When full, write and read pointers coincide; the head is read before the
    // edge that overwrites that slot, so push+pop on a full FIFO is safe.
    assign o_head = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/disp_switch.sv
// N-channel classify-and-route stage: class field selects a channel FIFO, an
// arbiter drains one word per cycle onto a registered payload bus.
module disp_switch
    import disp_switch_pkg::*;
#(
    parameter int DATA_SIZE  = DEF_DATA_SIZE,
    parameter int MAIN_SIZE  = DEF_MAIN_SIZE,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2,
    parameter int PRIO_MODE  = 0,
    localparam int CH_W      = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] in,
    input  logic                 in_valid,
    output logic                 in_pause,
    input  logic                 out_pause,
    output logic [MAIN_SIZE-1:0] out_data,
    output logic [CH_W-1:0]      out_ch,
    output logic                 out_valid,
    output logic [NUM_CH-1:0]    fifo_empty,
    output logic [NUM_CH-1:0]    fifo_full,
    output logic [NUM_CH-1:0]    almost_full,
    output logic [NUM_CH-1:0]    almost_empty,
    output logic [NUM_CH-1:0]    fifo_error,
    output logic                 Error
);

    logic [CH_W-1:0]      w_ch;
    logic [NUM_CH-1:0]    w_push;
    logic [NUM_CH-1:0]    w_pop;
    logic [NUM_CH-1:0]    w_drop;
    logic [MAIN_SIZE-1:0] w_head [NUM_CH];
    logic [CH_W-1:0]      w_start;
    logic [CH_W-1:0]      w_grant;
    logic                 w_found;
    logic                 w_pop_any;

    logic [MAIN_SIZE-1:0] r_out_data;
    logic [CH_W-1:0]      r_out_ch;
    logic                 r_out_valid;
    logic [CH_W-1:0]      r_last_grant;
    logic [NUM_CH-1:0]    r_fifo_error;

    assign w_ch = in[MAIN_SIZE +: CH_W];

    // Class bits above the channel index carry no routing information.
    if (DATA_SIZE > MAIN_SIZE + CH_W) begin : g_class_hi
        logic w_class_hi_unused;
        assign w_class_hi_unused = ^in[DATA_SIZE-1:MAIN_SIZE+CH_W];
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_push[g] = in_valid & (w_ch == CH_W'(g));

        sync_fifo #(
            .WIDTH     (MAIN_SIZE),
            .DEPTH     (FIFO_DEPTH),
            .AF_THRESH (AF_THRESH),
            .AE_THRESH (AE_THRESH)
        ) u_fifo (
            .clk            (clk),
            .reset          (reset),
            .i_push         (w_push[g]),
            .i_pop          (w_pop[g]),
            .i_data         (in[MAIN_SIZE-1:0]),
            .o_head         (w_head[g]),
            .o_empty        (fifo_empty[g]),
            .o_full         (fifo_full[g]),
            .o_almost_full  (almost_full[g]),
            .o_almost_empty (almost_empty[g]),
            .o_drop         (w_drop[g])
        );
    end

    // Strict priority always scans from channel 0; round robin scans from the
    // channel after the last one actually popped.
    assign w_start = is_round_robin(PRIO_MODE) ? r_last_grant + 1'b1 : '0;

    always_comb begin
        logic [CH_W-1:0] idx;
        w_found = 1'b0;
        w_grant = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = w_start + CH_W'(i);
            if (!w_found && !fifo_empty[idx]) begin
                w_found = 1'b1;
                w_grant = idx;
            end
        end
    end

    assign w_pop_any = ~out_pause & w_found;
    assign w_pop     = w_pop_any ? (NUM_CH'(1) << w_grant) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_ch     <= '0;
            r_last_grant <= CH_W'(NUM_CH - 1);
            r_fifo_error <= '0;
        end else begin
            r_out_valid  <= w_pop_any;
            r_fifo_error <= r_fifo_error | w_drop;
            if (w_pop_any) begin
                r_out_data   <= w_head[w_grant];
                r_out_ch     <= w_grant;
                r_last_grant <= w_grant;
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_ch     = r_out_ch;
    assign out_valid  = r_out_valid;
    assign fifo_error = r_fifo_error;
    assign Error      = |r_fifo_error;
    assign in_pause   = |almost_full;

endmodule

// File: tb/tb_disp_switch.sv
// Bench for disp_switch: strict-priority and round-robin instances share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_disp_switch;

    localparam int NCH   = 4;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       out_pause;
    logic [9:0] in_w;

    logic       d_valid [2];
    logic [7:0] d_data  [2];
    logic [1:0] d_ch    [2];
    logic [3:0] d_empty [2];
    logic [3:0] d_full  [2];
    logic [3:0] d_af    [2];
    logic [3:0] d_ae    [2];
    logic [3:0] d_err   [2];
    logic       d_Error [2];
    logic       d_pause [2];

    always #5 clk = ~clk;

    disp_switch #(.DATA_SIZE(10), .MAIN_SIZE(8), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH),
                  .AF_THRESH(6), .AE_THRESH(2), .PRIO_MODE(0)) u_sp (
        .clk(clk), .reset(reset), .in(in_w), .in_valid(in_valid), .in_pause(d_pause[0]),
        .out_pause(out_pause), .out_data(d_data[0]), .out_ch(d_ch[0]), .out_valid(d_valid[0]),
        .fifo_empty(d_empty[0]), .fifo_full(d_full[0]), .almost_full(d_af[0]),
        .almost_empty(d_ae[0]), .fifo_error(d_err[0]), .Error(d_Error[0]));

    disp_switch #(.DATA_SIZE(10), .MAIN_SIZE(8), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH),
                  .AF_THRESH(6), .AE_THRESH(2), .PRIO_MODE(1)) u_rr (
        .clk(clk), .reset(reset), .in(in_w), .in_valid(in_valid), .in_pause(d_pause[1]),
        .out_pause(out_pause), .out_data(d_data[1]), .out_ch(d_ch[1]), .out_valid(d_valid[1]),
        .fifo_empty(d_empty[1]), .fifo_full(d_full[1]), .almost_full(d_af[1]),
        .almost_empty(d_ae[1]), .fifo_error(d_err[1]), .Error(d_Error[1]));

    // Model state: one queue per (mode, channel), index m*NCH+ch.
    logic [7:0] mq [2*NCH][$];
    logic [3:0] merr [2];
    int         mlg  [2];
    logic       mov  [2];
    logic [7:0] mdat [2];
    logic [1:0] mch  [2];

    logic [9:0] cap  [2][$];
    int         capt [2][$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int m);
        bit         found;
        int         g;
        int         c;
        logic [1:0] ch;
        if (reset) begin
            for (int k = 0; k < NCH; k++) mq[m*NCH+k].delete();
            merr[m] = '0;
            mlg[m]  = NCH - 1;
            mov[m]  = 1'b0;
            mdat[m] = '0;
            mch[m]  = '0;
        end else begin
            found = 0;
            g     = 0;
            if (!out_pause) begin
                for (int i = 0; i < NCH; i++) begin
                    c = (m == 0) ? i : (mlg[m] + 1 + i) % NCH;
                    if (!found && mq[m*NCH+c].size() > 0) begin
                        found = 1;
                        g     = c;
                    end
                end
            end
            if (found) begin
                mdat[m] = mq[m*NCH+g].pop_front();
                mch[m]  = 2'(g);
                mov[m]  = 1'b1;
                mlg[m]  = g;
            end else begin
                mov[m] = 1'b0;
            end
            ch = in_w[9:8];
            if (in_valid) begin
                if (mq[m*NCH+int'(ch)].size() < DEPTH) mq[m*NCH+int'(ch)].push_back(in_w[7:0]);
                else merr[m][ch] = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        logic [3:0] e, f, a, ae;
        int sz;
        model_step(0);
        model_step(1);
        cyc++;
        #1;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < NCH; k++) begin
                sz    = mq[m*NCH+k].size();
                e[k]  = (sz == 0);
                f[k]  = (sz == DEPTH);
                a[k]  = (sz >= 6);
                ae[k] = (sz <= 2);
            end
            chk($sformatf("m%0d out_valid", m), 32'(d_valid[m]), 32'(mov[m]));
            chk($sformatf("m%0d out_data", m), 32'(d_data[m]), 32'(mdat[m]));
            chk($sformatf("m%0d out_ch", m), 32'(d_ch[m]), 32'(mch[m]));
            chk($sformatf("m%0d fifo_empty", m), 32'(d_empty[m]), 32'(e));
            chk($sformatf("m%0d fifo_full", m), 32'(d_full[m]), 32'(f));
            chk($sformatf("m%0d almost_full", m), 32'(d_af[m]), 32'(a));
            chk($sformatf("m%0d almost_empty", m), 32'(d_ae[m]), 32'(ae));
            chk($sformatf("m%0d fifo_error", m), 32'(d_err[m]), 32'(merr[m]));
            chk($sformatf("m%0d Error", m), 32'(d_Error[m]), 32'(|merr[m]));
            chk($sformatf("m%0d in_pause", m), 32'(d_pause[m]), 32'(|a));
            if (d_valid[m] === 1'b1) begin
                cap[m].push_back({d_ch[m], d_data[m]});
                capt[m].push_back(cyc);
            end
        end
    end

    task automatic push(input logic [9:0] w);
        in_w     = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_caps();
        for (int m = 0; m < 2; m++) begin
            cap[m].delete();
            capt[m].delete();
        end
    endtask

    task automatic chk_cap(input int m, input int idx, input logic [9:0] exp);
        if (cap[m].size() > idx) chk($sformatf("m%0d word%0d", m, idx), 32'(cap[m][idx]), 32'(exp));
        else chk($sformatf("m%0d word%0d missing", m, idx), 32'hDEAD, 32'(exp));
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s m%0d valid", tag, m), 32'(d_valid[m]), 0);
            chk($sformatf("%s m%0d data", tag, m), 32'(d_data[m]), 0);
            chk($sformatf("%s m%0d ch", tag, m), 32'(d_ch[m]), 0);
            chk($sformatf("%s m%0d empty", tag, m), 32'(d_empty[m]), 32'hF);
            chk($sformatf("%s m%0d ae", tag, m), 32'(d_ae[m]), 32'hF);
            chk($sformatf("%s m%0d full", tag, m), 32'(d_full[m]), 0);
            chk($sformatf("%s m%0d err", tag, m), 32'(d_err[m]), 0);
            chk($sformatf("%s m%0d pause", tag, m), 32'(d_pause[m]), 0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_pause = 1'b0;
        in_w      = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("init");

        // Routing: class 2 payload A5, visible two edges after the push.
        in_w     = 10'h2A5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("route mid valid", 32'(d_valid[0]), 0);
        chk("route mid empty", 32'(d_empty[0]), 32'hB);
        @(negedge clk);
        chk("route valid", 32'(d_valid[0]), 1);
        chk("route data", 32'(d_data[0]), 32'hA5);
        chk("route ch", 32'(d_ch[0]), 2);
        chk("route empty", 32'(d_empty[0]), 32'hF);

        // Strict priority vs round robin on the same backlog.
        do_reset();
        out_pause = 1'b1;
        push(10'h311); push(10'h312); push(10'h001); push(10'h002);
        clear_caps();
        out_pause = 1'b0;
        repeat (6) @(negedge clk);
        chk("sp count", cap[0].size(), 4);
        chk_cap(0, 0, {2'd0, 8'h01}); chk_cap(0, 1, {2'd0, 8'h02});
        chk_cap(0, 2, {2'd3, 8'h11}); chk_cap(0, 3, {2'd3, 8'h12});
        chk("rr count", cap[1].size(), 4);
        chk_cap(1, 0, {2'd0, 8'h01}); chk_cap(1, 1, {2'd3, 8'h11});
        chk_cap(1, 2, {2'd0, 8'h02}); chk_cap(1, 3, {2'd3, 8'h12});
        for (int m = 0; m < 2; m++)
            if (capt[m].size() == 4) chk($sformatf("m%0d back-to-back", m), capt[m][3] - capt[m][0], 3);

        // Flags and overflow on channel 1.
        do_reset();
        out_pause = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            push({2'd1, 8'(8'h3F + i)});
            chk($sformatf("ovf af%0d", i), 32'(d_af[0][1]), 32'(i >= 6));
            chk($sformatf("ovf in_pause%0d", i), 32'(d_pause[0]), 32'(i >= 6));
            chk($sformatf("ovf full%0d", i), 32'(d_full[0][1]), 32'(i >= 8));
            chk($sformatf("ovf err%0d", i), 32'(d_err[0]), (i >= 9) ? 32'h2 : 32'h0);
        end
        chk("ovf Error", 32'(d_Error[1]), 1);
        clear_caps();
        out_pause = 1'b0;
        repeat (12) @(negedge clk);
        chk("ovf drained", cap[0].size(), 8);
        for (int k = 0; k < 8; k++) chk_cap(0, k, {2'd1, 8'(8'h40 + k)});
        chk("ovf Error sticky", 32'(d_Error[0]), 1);

        // Full FIFO with push and pop in the same cycle.
        do_reset();
        out_pause = 1'b1;
        for (int k = 0; k < 8; k++) push({2'd0, 8'(8'h80 + k)});
        clear_caps();
        in_w      = {2'd0, 8'hEE};
        in_valid  = 1'b1;
        out_pause = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pp err", 32'(d_err[0]), 0);
        chk("pp full", 32'(d_full[0][0]), 1);
        repeat (12) @(negedge clk);
        chk("pp drained", cap[0].size(), 9);
        chk_cap(0, 8, {2'd0, 8'hEE});
        chk("pp Error", 32'(d_Error[0]), 0);

        // Reset with words buffered.
        do_reset();
        out_pause = 1'b1;
        push(10'h2C1); push(10'h2C2); push(10'h2C3);
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        out_pause = 1'b0;
        clear_caps();
        chk_reset_vals("midrst");
        repeat (10) @(negedge clk);
        chk("midrst no stale sp", cap[0].size(), 0);
        chk("midrst no stale rr", cap[1].size(), 0);

        // Randomized traffic in phases of light, medium and heavy backpressure.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int n = 0; n < 1000; n++) begin
                in_valid  = ($urandom_range(0, 99) < 60);
                in_w      = 10'($urandom);
                out_pause = ($urandom_range(0, 99) < (10 + 40 * p));
                reset     = ($urandom_range(0, 499) == 0);
                @(negedge clk);
            end
        end
        in_valid  = 1'b0;
        out_pause = 1'b0;
        reset     = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
